// File: rtl/soc_pkg.sv
// Shared AXI4 channel structs, response codes and the
// register-responder FSM state types.
package soc_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } s_ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } s_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } s_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } s_r_t;

  typedef struct packed {
    s_ax_t aw;
    logic  aw_valid;
    s_w_t  w;
    logic  w_valid;
    logic  b_ready;
    s_ax_t ar;
    logic  ar_valid;
    logic  r_ready;
  } s_req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    logic ar_ready;
    logic b_valid;
    s_b_t b;
    logic r_valid;
    s_r_t r;
  } s_resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } axi_reg_w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } axi_reg_r_state_e;

  function automatic logic [1:0] axi_reg_resp(
    input logic hit,
    input logic single
  );
    if (!hit) return AXI_RESP_DECERR;
    if (!single) return AXI_RESP_SLVERR;
    return AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_reg_addr_decode.sv
// Maps a byte address onto the register window:
// hit flag plus 64-bit register index.
module axi_reg_addr_decode
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE     = '0,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // 33-bit bounds so a window ending at 4 GiB cannot wrap
  localparam logic [32:0] LO = {1'b0, BASE};
  localparam logic [32:0] HI = LO + 33'(NUM_REGS) * 33'd8;

  logic [31:0] off;

  assign off = addr - BASE;
  assign hit = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
  assign idx = IDX_W'(off >> 3);

endmodule

// File: rtl/axi_reg_responder.sv
// AXI4 subordinate terminating single-beat accesses
// into a bank of 64-bit registers; bursts get SLVERR.
module axi_reg_responder
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE     = '0,
  parameter int unsigned NUM_REGS = 16,
  parameter type         req_t    = s_req_t,
  parameter type         resp_t   = s_resp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  req_t                       req_i,
  output resp_t                      resp_o,
  output logic [NUM_REGS-1:0][63:0]  regs_o
);

  localparam int unsigned IDX_W =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  axi_reg_w_state_e w_q, w_d;
  axi_reg_r_state_e r_q, r_d;

  logic [NUM_REGS-1:0][63:0] regs_q;

  logic             aw_hit, ar_hit;
  logic [IDX_W-1:0] aw_idx, ar_idx;

  logic [3:0]       w_id_q;
  logic             w_hit_q, w_one_q;
  logic [IDX_W-1:0] w_idx_q;

  logic [3:0]       r_id_q;
  logic             r_hit_q, r_one_q;
  logic [7:0]       r_cnt_q;
  logic [63:0]      r_data_q;

  logic aw_ready, w_ready, ar_ready;
  logic b_valid, r_valid, r_last;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic commit;
  logic unused;

  axi_reg_addr_decode #(
    .BASE     (BASE),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_aw_dec (
    .addr (req_i.aw.addr),
    .hit  (aw_hit),
    .idx  (aw_idx)
  );

  axi_reg_addr_decode #(
    .BASE     (BASE),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_ar_dec (
    .addr (req_i.ar.addr),
    .hit  (ar_hit),
    .idx  (ar_idx)
  );

  // Handshake signals are forced low while reset is held
  assign aw_ready = !rst_i && (w_q == W_IDLE);
  assign w_ready  = !rst_i && (w_q == W_DATA);
  assign b_valid  = !rst_i && (w_q == W_RESP);
  assign ar_ready = !rst_i && (r_q == R_IDLE);
  assign r_valid  = !rst_i && (r_q == R_DATA);
  assign r_last   = (r_cnt_q == 8'd0);

  assign aw_hs = req_i.aw_valid && aw_ready;
  assign w_hs  = req_i.w_valid && w_ready;
  assign b_hs  = req_i.b_ready && b_valid;
  assign ar_hs = req_i.ar_valid && ar_ready;
  assign r_hs  = req_i.r_ready && r_valid;

  assign commit = w_hs && w_one_q && w_hit_q;

  assign unused = ^{req_i.aw.size, req_i.aw.burst,
                    req_i.ar.size, req_i.ar.burst};

  always_comb begin
    resp_o          = '0;
    resp_o.aw_ready = aw_ready;
    resp_o.w_ready  = w_ready;
    resp_o.ar_ready = ar_ready;
    resp_o.b_valid  = b_valid;
    resp_o.b.id     = w_id_q;
    resp_o.b.resp   = axi_reg_resp(w_hit_q, w_one_q);
    resp_o.r_valid  = r_valid;
    resp_o.r.id     = r_id_q;
    resp_o.r.data   = r_data_q;
    resp_o.r.resp   = axi_reg_resp(r_hit_q, r_one_q);
    resp_o.r.last   = r_last;
  end

  always_comb begin
    w_d = w_q;
    unique case (w_q)
      W_IDLE: if (aw_hs) w_d = W_DATA;
      W_DATA: if (w_hs && req_i.w.last) w_d = W_RESP;
      W_RESP: if (b_hs) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_d = r_q;
    unique case (r_q)
      R_IDLE: if (ar_hs) r_d = R_DATA;
      R_DATA: if (r_hs && r_last) r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_q <= W_IDLE;
      r_q <= R_IDLE;
    end else begin
      w_q <= w_d;
      r_q <= r_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q  <= '0;
      w_id_q  <= '0;
      w_hit_q <= 1'b0;
      w_one_q <= 1'b0;
      w_idx_q <= '0;
    end else begin
      if (aw_hs) begin
        w_id_q  <= req_i.aw.id;
        w_hit_q <= aw_hit;
        w_one_q <= (req_i.aw.len == 8'd0);
        w_idx_q <= aw_idx;
      end
      for (int k = 0; k < 8; k++) begin
        if (commit && req_i.w.strb[k]) begin
          regs_q[w_idx_q][8*k +: 8] <= req_i.w.data[8*k +: 8];
        end
      end
    end
  end

  // Snapshot reads regs_q, so a same-edge commit is not visible
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id_q   <= '0;
      r_hit_q  <= 1'b0;
      r_one_q  <= 1'b0;
      r_cnt_q  <= '0;
      r_data_q <= '0;
    end else if (ar_hs) begin
      r_id_q   <= req_i.ar.id;
      r_hit_q  <= ar_hit;
      r_one_q  <= (req_i.ar.len == 8'd0);
      r_cnt_q  <= req_i.ar.len;
      r_data_q <= (ar_hit && req_i.ar.len == 8'd0) ?
                  regs_q[ar_idx] : '0;
    end else if (r_hs && !r_last) begin
      r_cnt_q <= r_cnt_q - 8'd1;
    end
  end

  assign regs_o = regs_q;

endmodule
